// File: rtl/alu_result_fifo.sv
// alu_result_fifo: circular FIFO buffering ALU results {cf, sf, zf, r} between
// the NOT/SHL ALU and a consumer that may stall, over valid/ready handshakes.
// Optional feature macro: ALU_RESULT_FIFO_STICKY_EN adds sticky carry/zero
// flag registers (sticky_clr, sticky_cf, sticky_zf) that accumulate pushed flags.

module alu_result_fifo #(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
`ifdef ALU_RESULT_FIFO_STICKY_EN
   input  logic          sticky_clr,
   output logic          sticky_cf,
   output logic          sticky_zf,
`endif
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [4:0]    in_r,
   input  logic          in_cf,
   input  logic          in_sf,
   input  logic          in_zf,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [4:0]    out_r,
   output logic          out_cf,
   output logic          out_sf,
   output logic          out_zf,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   localparam int unsigned CW = AW + 1;
   localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

   typedef struct packed {
      logic       cf;
      logic       sf;
      logic       zf;
      logic [4:0] r;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;

   // Status flags come only from the occupancy register
   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign in_ready  = !full;
   assign out_valid = !empty;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   // Head entry is read straight out of storage and blanked when nothing is held
   assign head   = mem[rd_ptr];
   assign out_r  = empty ? 5'd0 : head.r;
   assign out_cf = empty ? 1'b0 : head.cf;
   assign out_sf = empty ? 1'b0 : head.sf;
   assign out_zf = empty ? 1'b0 : head.zf;

   // Storage array, written at the tail on every accepted push (not reset)
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem[wr_ptr] <= '{cf: in_cf, sf: in_sf, zf: in_zf, r: in_r};
      end
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef ALU_RESULT_FIFO_STICKY_EN
   // Sticky flags: clear takes effect first, then the pushed flags are ORed in
   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_cf <= 1'b0;
         sticky_zf <= 1'b0;
      end else begin
         sticky_cf <= (sticky_clr ? 1'b0 : sticky_cf) | (push & in_cf);
         sticky_zf <= (sticky_clr ? 1'b0 : sticky_zf) | (push & in_zf);
      end
   end
`endif

endmodule
